alu_sequencer: RTL and testbench

Command-side driver for the 16-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand, select, enable and carry_in pins. It captures data, carry_out and zero_flag, and returns registered results over a second valid/ready handshake. A 32-bit operation runs as two chained 16-bit ALU passes, with carry_out of the low half feeding carry_in of the high half. Persistent carry and zero flags are kept for multi-precision use.

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared widths and FSM encoding for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned ALU_W = 16;
    localparam int unsigned REQ_W = 32;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Drives a 16-bit ALU for narrow and chained 32-bit operations, returning registered
// results over a valid/ready handshake and keeping persistent carry/zero flags.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_op,
    input  logic             req_wide,
    input  logic             req_use_carry,
    input  logic [REQ_W-1:0] req_a,
    input  logic [REQ_W-1:0] req_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [REQ_W-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,

    output logic             flag_carry,
    output logic             flag_zero,
    input  logic             flag_clear,

    output logic [ALU_W-1:0] alu_in_1,
    output logic [ALU_W-1:0] alu_in_2,
    output logic [SEL_W-1:0] alu_select,
    output logic             alu_enable,
    output logic             alu_carry_in,
    input  logic [ALU_W-1:0] alu_data,
    input  logic             alu_carry_out,
    input  logic             alu_zero_flag
);

    state_t             state_q, state_d;

    logic [SEL_W-1:0]   op_q;
    logic               wide_q;
    logic               use_carry_q;
    logic [REQ_W-1:0]   a_q;
    logic [REQ_W-1:0]   b_q;

    logic [ALU_W-1:0]   lo_data_q;
    logic               lo_carry_q;
    logic               lo_zero_q;

    logic [REQ_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_load;

    logic               flag_carry_q;
    logic               flag_zero_q;

    // Next state, ALU pin drive and handshake outputs; ALU pins idle at zero.
    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_in_1     = '0;
        alu_in_2     = '0;
        alu_select   = '0;
        alu_enable   = 1'b0;
        alu_carry_in = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LO;
            end
            LO: begin
                alu_in_1     = a_q[ALU_W-1:0];
                alu_in_2     = b_q[ALU_W-1:0];
                alu_select   = op_q;
                alu_enable   = 1'b1;
                alu_carry_in = use_carry_q & flag_carry_q;
                state_d      = wide_q ? HI : RESP;
            end
            HI: begin
                alu_in_1     = a_q[REQ_W-1:ALU_W];
                alu_in_2     = b_q[REQ_W-1:ALU_W];
                alu_select   = op_q;
                alu_enable   = 1'b1;
                alu_carry_in = lo_carry_q;
                state_d      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
        endcase
    end

    // Result composed from the final ALU pass; loaded on the edge entering RESP.
    always_comb begin
        rsp_load    = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        if (state_q == LO && !wide_q) begin
            rsp_load    = 1'b1;
            rsp_data_d  = {{(REQ_W-ALU_W){1'b0}}, alu_data};
            rsp_carry_d = alu_carry_out;
            rsp_zero_d  = alu_zero_flag;
        end else if (state_q == HI) begin
            rsp_load    = 1'b1;
            rsp_data_d  = {alu_data, lo_data_q};
            rsp_carry_d = alu_carry_out;
            rsp_zero_d  = lo_zero_q & alu_zero_flag;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Request latch on acceptance and low-half capture for the carry chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= '0;
            wide_q      <= 1'b0;
            use_carry_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            lo_data_q   <= '0;
            lo_carry_q  <= 1'b0;
            lo_zero_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                op_q        <= req_op;
                wide_q      <= req_wide;
                use_carry_q <= req_use_carry;
                a_q         <= req_a;
                b_q         <= req_b;
            end
            if (state_q == LO) begin
                lo_data_q  <= alu_data;
                lo_carry_q <= alu_carry_out;
                lo_zero_q  <= alu_zero_flag;
            end
        end
    end

    // Response registers and persistent flags; a flag update beats flag_clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
        end else begin
            if (rsp_load) begin
                rsp_data_q   <= rsp_data_d;
                rsp_carry_q  <= rsp_carry_d;
                rsp_zero_q   <= rsp_zero_d;
                flag_carry_q <= rsp_carry_d;
                flag_zero_q  <= rsp_zero_d;
            end else if (flag_clear) begin
                flag_carry_q <= 1'b0;
                flag_zero_q  <= 1'b0;
            end
        end
    end

    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_zero   = rsp_zero_q;
    assign flag_carry = flag_carry_q;
    assign flag_zero  = flag_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 16-bit ALU alongside.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_wide;
    logic        req_use_carry;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_zero;
    logic        flag_carry;
    logic        flag_zero;
    logic        flag_clear;
    logic [15:0] alu_in_1;
    logic [15:0] alu_in_2;
    logic [2:0]  alu_select;
    logic        alu_enable;
    logic        alu_carry_in;
    logic [15:0] alu_data;
    logic        alu_carry_out;
    logic        alu_zero_flag;

    int checks   = 0;
    int failures = 0;

    alu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_wide      (req_wide),
        .req_use_carry (req_use_carry),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_carry     (rsp_carry),
        .rsp_zero      (rsp_zero),
        .flag_carry    (flag_carry),
        .flag_zero     (flag_zero),
        .flag_clear    (flag_clear),
        .alu_in_1      (alu_in_1),
        .alu_in_2      (alu_in_2),
        .alu_select    (alu_select),
        .alu_enable    (alu_enable),
        .alu_carry_in  (alu_carry_in),
        .alu_data      (alu_data),
        .alu_carry_out (alu_carry_out),
        .alu_zero_flag (alu_zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: 0 add-with-carry, 1 and, 2 or, 3 xor, others pass in_1.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum       = 17'(alu_in_1) + 17'(alu_in_2) + 17'(alu_carry_in);
        alu_data      = '0;
        alu_carry_out = 1'b0;
        alu_zero_flag = 1'b0;
        if (alu_enable) begin
            case (alu_select)
                3'd0:    {alu_carry_out, alu_data} = alu_sum;
                3'd1:    alu_data = alu_in_1 & alu_in_2;
                3'd2:    alu_data = alu_in_1 | alu_in_2;
                3'd3:    alu_data = alu_in_1 ^ alu_in_2;
                default: alu_data = alu_in_1;
            endcase
            alu_zero_flag = (alu_data == 16'h0);
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic        wide;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        carry;
        logic        zero;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the first RESP cycle.
    task automatic do_op(input logic [2:0] op, input logic wide, input logic uc,
                         input logic [31:0] a, input logic [31:0] b, output int lat);
        req_op        = op;
        req_wide      = wide;
        req_use_carry = uc;
        req_a         = a;
        req_b         = b;
        req_valid     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles required <= 3", lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach end, required completion");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0] = '{3'd0, 1'b0, 32'h0000_1234, 32'h0000_0001, 32'h0000_1235, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0};
        vecs[2] = '{3'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{3'd0, 1'b0, 32'hABCD_FFFF, 32'h1234_0001, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{3'd0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};
        vecs[5] = '{3'd1, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0};
        vecs[6] = '{3'd3, 1'b1, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000, 1'b0, 1'b1};
        vecs[7] = '{3'd0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_wide = 1'b0;
        req_use_carry = 1'b0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        flag_clear = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_ctrl", 32'({rsp_valid, rsp_carry, rsp_zero, flag_carry, flag_zero,
                                 alu_enable, alu_carry_in, alu_select}), 32'h0);
        check("reset_alu_in", {alu_in_1, alu_in_2}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven operations with rsp_ready held high.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].op, vecs[i].wide, 1'b0, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].wide ? 32'd3 : 32'd2);
            check($sformatf("v%0d_data", i), rsp_data, vecs[i].data);
            check($sformatf("v%0d_carry", i), 32'(rsp_carry), 32'(vecs[i].carry));
            check($sformatf("v%0d_zero", i), 32'(rsp_zero), 32'(vecs[i].zero));
            check($sformatf("v%0d_flags", i), 32'({flag_carry, flag_zero}),
                  32'({vecs[i].carry, vecs[i].zero}));
            @(negedge clk);
            check($sformatf("v%0d_ready_after", i), 32'(req_ready), 32'd1);
        end

        // Carry chain visible on the ALU pins, cycle by cycle.
        req_op = 3'd0; req_wide = 1'b1; req_use_carry = 1'b0;
        req_a = 32'h0000_FFFF; req_b = 32'h0000_0001; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("lo_pins", {alu_in_1, alu_in_2}, 32'hFFFF_0001);
        check("lo_ctrl", 32'({alu_enable, alu_carry_in, req_ready}), 32'b100);
        @(negedge clk);
        check("hi_pins", {alu_in_1, alu_in_2}, 32'h0000_0000);
        check("hi_carry_in", 32'({alu_enable, alu_carry_in}), 32'b11);
        @(negedge clk);
        check("chain_resp", {31'(rsp_valid), alu_enable}, 32'h2);
        check("chain_data", rsp_data, 32'h0001_0000);
        @(negedge clk);

        // Stored carry feeds the next narrow op.
        do_op(3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        check("ovf_flag_carry", 32'(flag_carry), 32'd1);
        @(negedge clk);
        do_op(3'd0, 1'b0, 1'b1, 32'h0, 32'h0, lat);
        check("use_carry_data", rsp_data, 32'h0000_0001);
        check("use_carry_flags", 32'({flag_carry, flag_zero}), 32'b00);
        @(negedge clk);

        // Backpressure: response held stable and new requests refused.
        rsp_ready = 1'b0;
        do_op(3'd0, 1'b0, 1'b0, 32'h0000_00AA, 32'h0000_0011, lat);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 32'({rsp_valid, req_ready}), 32'b10);
            check($sformatf("bp%0d_data", i), rsp_data, 32'h0000_00BB);
            if (i == 1) begin
                req_a = 32'h0000_5555; req_b = 32'h0000_5555; req_valid = 1'b1;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'({req_ready, rsp_valid}), 32'b10);
        @(negedge clk);
        check("bp_no_accept", 32'({req_ready, rsp_valid, alu_enable}), 32'b100);
        check("bp_data_held", rsp_data, 32'h0000_00BB);

        // flag_clear while entering RESP loses to the flag update.
        req_op = 3'd0; req_wide = 1'b0; req_use_carry = 1'b0;
        req_a = 32'h0000_FFFF; req_b = 32'h0000_0001; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flag_clear = 1'b1;
        @(negedge clk);
        flag_clear = 1'b0;
        check("clear_on_update", 32'({flag_carry, flag_zero}), 32'b11);
        @(negedge clk);
        // flag_clear in IDLE clears both.
        flag_clear = 1'b1;
        @(negedge clk);
        flag_clear = 1'b0;
        check("clear_idle", 32'({flag_carry, flag_zero}), 32'b00);

        // Reset during HI abandons the operation and resets flags.
        do_op(3'd0, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, lat);
        @(negedge clk);
        req_op = 3'd0; req_wide = 1'b1; req_a = 32'h1; req_b = 32'h1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_hi", 32'(alu_enable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_hi_state", 32'({req_ready, rsp_valid, alu_enable}), 32'b100);
        check("rst_hi_flags", 32'({flag_carry, flag_zero}), 32'b00);
        repeat (3) @(negedge clk);
        check("rst_hi_no_rsp", 32'({req_ready, rsp_valid}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
